// File: rtl/bcd_7seg_scan.sv
// Multiplexed seven-segment driver for packed BCD words; new words are applied at frame boundaries.
// Optional leading-zero blanking is enabled by defining LZ_BLANK_EN.
module bcd_7seg_scan #(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 4
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic [4*N_DIGITS-1:0]   Bcd,
  input  logic [N_DIGITS-1:0]     Dp,
  input  logic                    Valid,
  input  logic                    Blank,
  output logic [6:0]              Seg,
  output logic                    DpOut,
  output logic [N_DIGITS-1:0]     An,
  output logic                    Pending
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [CW-1:0]       CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]       CNT_GUARD = CW'(GUARD);
  localparam logic [IW-1:0]       IDX_LAST  = IW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_ONE    = N_DIGITS'(1);

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  logic [CW-1:0]         cnt_p0;
  logic [IW-1:0]         idx_p0;
  logic [4*N_DIGITS-1:0] pend_bcd, disp_bcd;
  logic [N_DIGITS-1:0]   pend_dp, disp_dp;
  logic                  pending_q;
  logic [6:0]            seg_p1;
  logic                  dp_p1;
  logic [N_DIGITS-1:0]   an_p1;

  logic                  frame_end;
  logic [N_DIGITS-1:0]   lz_mask;
  logic [3:0]            cur_digit;
  logic                  cur_dp;
  logic                  cur_lz;

  assign frame_end = (cnt_p0 == CNT_LAST) && (idx_p0 == IDX_LAST);

`ifdef LZ_BLANK_EN
  logic upper_zero;

  // Digit k is suppressed while it and every more-significant digit are zero.
  always_comb begin
    upper_zero = 1'b1;
    lz_mask    = '0;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero & (disp_bcd[4*k +: 4] == 4'd0);
      lz_mask[k] = upper_zero;
    end
  end
`else
  assign lz_mask = '0;
`endif

  always_comb begin
    cur_digit = 4'd0;
    cur_dp    = 1'b0;
    cur_lz    = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_p0 == IW'(k)) begin
        cur_digit = disp_bcd[4*k +: 4];
        cur_dp    = disp_dp[k];
        cur_lz    = lz_mask[k];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      cnt_p0    <= '0;
      idx_p0    <= '0;
      pend_bcd  <= '0;
      pend_dp   <= '0;
      disp_bcd  <= '0;
      disp_dp   <= '0;
      pending_q <= 1'b0;
      seg_p1    <= 7'h7F;
      dp_p1     <= 1'b1;
      an_p1     <= '1;
    end else begin
      // p0: slot counter and digit index
      if (cnt_p0 == CNT_LAST) begin
        cnt_p0 <= '0;
        idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + IW'(1);
      end else begin
        cnt_p0 <= cnt_p0 + CW'(1);
      end

      // Display takes the old pending word even when a new one lands on the same edge.
      if (frame_end && pending_q) begin
        disp_bcd <= pend_bcd;
        disp_dp  <= pend_dp;
      end
      if (Valid) begin
        pend_bcd <= Bcd;
        pend_dp  <= Dp;
      end
      if (Valid)
        pending_q <= 1'b1;
      else if (frame_end)
        pending_q <= 1'b0;

      // p1: registered segment, decimal point and anode drive
      seg_p1 <= cur_lz ? 7'h7F : seg_decode(cur_digit);
      dp_p1  <= ~cur_dp;
      an_p1  <= ((cnt_p0 >= CNT_GUARD) && !Blank && !cur_lz) ? ~(AN_ONE << idx_p0) : '1;
    end
  end

  assign Seg     = seg_p1;
  assign DpOut   = dp_p1;
  assign An      = an_p1;
  assign Pending = pending_q;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Scoreboard bench for bcd_7seg_scan (N_DIGITS=4, REFRESH_DIV=8, GUARD=2).
// Expectations are tagged with the clock edge after which they hold.
module tb_bcd_7seg_scan;

  localparam int ND = 4;
`ifdef LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic [15:0]   Bcd;
  logic [3:0]    Dp;
  logic          Valid;
  logic          Blank;
  logic [6:0]    Seg;
  logic          DpOut;
  logic [3:0]    An;
  logic          Pending;

  bcd_7seg_scan #(.N_DIGITS(ND), .REFRESH_DIV(8), .GUARD(2)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Bcd(Bcd), .Dp(Dp), .Valid(Valid), .Blank(Blank),
    .Seg(Seg), .DpOut(DpOut), .An(An), .Pending(Pending)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    string      name;
    bit [3:0]   en;   // {pend, dp, an, seg}
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       pend;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic void expect_at(int c, string nm, bit [3:0] en, logic [6:0] s,
                                    logic [3:0] a, logic d, logic p);
    exp_t e;
    int   i;
    e.c = c; e.name = nm; e.en = en; e.seg = s; e.an = a; e.dp = d; e.pend = p;
    i = 0;
    while (i < q.size() && q[i].c <= c) i++;
    q.insert(i, e);
  endfunction

  // Monitor: compares whatever the DUT presents against the queued expectation for this edge.
  always @(negedge Clk) begin
    while (q.size() > 0 && q[0].c <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.c < cyc) begin
        tests++; fails++;
        $display("FAIL %s missed check at edge %0d (now %0d)", e.name, e.c, cyc);
      end else begin
        if (e.en[0]) begin
          tests++;
          if (Seg !== e.seg) begin
            fails++;
            $display("FAIL %s Seg @%0d: got %b want %b", e.name, cyc, Seg, e.seg);
          end
        end
        if (e.en[1]) begin
          tests++;
          if (An !== e.an) begin
            fails++;
            $display("FAIL %s An @%0d: got %h want %h", e.name, cyc, An, e.an);
          end
        end
        if (e.en[2]) begin
          tests++;
          if (DpOut !== e.dp) begin
            fails++;
            $display("FAIL %s DpOut @%0d: got %b want %b", e.name, cyc, DpOut, e.dp);
          end
        end
        if (e.en[3]) begin
          tests++;
          if (Pending !== e.pend) begin
            fails++;
            $display("FAIL %s Pending @%0d: got %b want %b", e.name, cyc, Pending, e.pend);
          end
        end
      end
    end
  end

  task automatic at(input int n);
    while (cyc < n) @(negedge Clk);
  endtask

  task automatic load(input int edge_n, input logic [15:0] b, input logic [3:0] d);
    at(edge_n - 1);
    Valid = 1'b1; Bcd = b; Dp = d;
    at(edge_n);
    Valid = 1'b0;
  endtask

  initial begin
    int d, s;
    logic [3:0] a;
    Rst_n = 1'b0; Valid = 1'b0; Bcd = '0; Dp = '0; Blank = 1'b0;

    // Reset held for edges 1..3; first running edge is 4, digit 0 lights at edge 6.
    expect_at(2, "rst", 4'b1111, 7'h7F, 4'hF, 1'b1, 1'b0);
    expect_at(3, "rst", 4'b1111, 7'h7F, 4'hF, 1'b1, 1'b0);
    expect_at(5, "guard0", 4'b0010, 7'h00, 4'hF, 1'b1, 1'b0);
    expect_at(6, "first_an", 4'b0011, 7'h40, 4'hE, 1'b1, 1'b0);
    at(3);
    Rst_n = 1'b1;

    // Tear-free load of 1234 captured mid-frame at edge 15; applied at boundary edge 35.
    expect_at(15, "pend_set", 4'b1000, 7'h00, 4'hF, 1'b1, 1'b1);
    expect_at(32, "old_d3", 4'b0011, LZ ? 7'h7F : 7'h40, LZ ? 4'hF : 4'h7, 1'b1, 1'b0);
    expect_at(34, "pend_hold", 4'b1000, 7'h00, 4'hF, 1'b1, 1'b1);
    expect_at(35, "pend_clr", 4'b1000, 7'h00, 4'hF, 1'b1, 1'b0);
    expect_at(39, "d0_4", 4'b0111, 7'h19, 4'hE, 1'b1, 1'b0);
    expect_at(49, "d1_3", 4'b0111, 7'h30, 4'hD, 1'b1, 1'b0);
    expect_at(53, "guard_d2", 4'b0010, 7'h00, 4'hF, 1'b1, 1'b0);
    expect_at(54, "d2_on", 4'b0010, 7'h00, 4'hB, 1'b1, 1'b0);
    expect_at(57, "d2_2", 4'b0011, 7'h24, 4'hB, 1'b1, 1'b0);
    expect_at(63, "d3_1", 4'b0011, 7'h79, 4'h7, 1'b1, 1'b0);
    load(15, 16'h1234, 4'b0000);

    // Coincident strobes at boundary edges 67 and 99.
    expect_at(67, "c5_pend", 4'b1000, 7'h00, 4'hF, 1'b1, 1'b1);
    expect_at(71, "c_still4", 4'b0001, 7'h19, 4'hF, 1'b1, 1'b0);
    expect_at(99, "c9_pend", 4'b1000, 7'h00, 4'hF, 1'b1, 1'b1);
    expect_at(103, "c_shows5", 4'b0011, 7'h12, 4'hE, 1'b1, 1'b0);
    expect_at(127, "c_d3_0", 4'b0011, LZ ? 7'h7F : 7'h40, LZ ? 4'hF : 4'h7, 1'b1, 1'b0);
    expect_at(130, "c_pend1", 4'b1000, 7'h00, 4'hF, 1'b1, 1'b1);
    expect_at(131, "c_pend0", 4'b1000, 7'h00, 4'hF, 1'b1, 1'b0);
    expect_at(135, "c_shows9", 4'b0011, 7'h10, 4'hE, 1'b1, 1'b0);
    load(67, 16'h0005, 4'b0000);
    load(99, 16'h0009, 4'b0000);

    // 8888 with Dp on digit 1, displayed through frame 5 (edges 164..195).
    for (int i = 0; i < 32; i++) begin
      d = i / 8;
      s = i % 8;
      a = (s >= 2) ? ~(4'b0001 << d) : 4'hF;
      expect_at(164 + i, "scan", 4'b0111, 7'h00, a, (d == 1) ? 1'b0 : 1'b1, 1'b0);
    end
    load(140, 16'h8888, 4'b0010);

    // Blank high for edges 202..221.
    expect_at(201, "blk_pre", 4'b0010, 7'h00, 4'hE, 1'b1, 1'b0);
    expect_at(202, "blk_rise", 4'b0010, 7'h00, 4'hF, 1'b1, 1'b0);
    expect_at(210, "blk_dp", 4'b0110, 7'h00, 4'hF, 1'b0, 1'b0);
    expect_at(221, "blk_last", 4'b0010, 7'h00, 4'hF, 1'b1, 1'b0);
    expect_at(222, "blk_fall", 4'b0010, 7'h00, 4'h7, 1'b1, 1'b0);
    expect_at(223, "blk_after", 4'b0110, 7'h00, 4'h7, 1'b1, 1'b0);
    at(201);
    Blank = 1'b1;
    at(221);
    Blank = 1'b0;

    // 0070 displayed in frame 7 (edges 228..259).
    expect_at(226, "lz_pend", 4'b1000, 7'h00, 4'hF, 1'b1, 1'b1);
    expect_at(227, "lz_pclr", 4'b1000, 7'h00, 4'hF, 1'b1, 1'b0);
    expect_at(232, "lz_d0", 4'b0011, 7'h40, 4'hE, 1'b1, 1'b0);
    expect_at(240, "lz_d1", 4'b0111, 7'h78, 4'hD, 1'b1, 1'b0);
    expect_at(248, "lz_d2", 4'b0011, LZ ? 7'h7F : 7'h40, LZ ? 4'hF : 4'hB, 1'b1, 1'b0);
    expect_at(256, "lz_d3", 4'b0011, LZ ? 7'h7F : 7'h40, LZ ? 4'hF : 4'h7, 1'b1, 1'b0);
    load(225, 16'h0070, 4'b0000);

    // Mid-frame reset at edges 265..266 discards the pending 1234.
    expect_at(262, "mr_pend", 4'b1000, 7'h00, 4'hF, 1'b1, 1'b1);
    expect_at(265, "mr_rst", 4'b1111, 7'h7F, 4'hF, 1'b1, 1'b0);
    expect_at(268, "mr_guard", 4'b0010, 7'h00, 4'hF, 1'b1, 1'b0);
    expect_at(269, "mr_first", 4'b0011, 7'h40, 4'hE, 1'b1, 1'b0);
    expect_at(299, "mr_nopend", 4'b1000, 7'h00, 4'hF, 1'b1, 1'b0);
    expect_at(302, "mr_zero", 4'b0011, 7'h40, 4'hE, 1'b1, 1'b0);
    load(262, 16'h1234, 4'b1111);
    at(264);
    Rst_n = 1'b0;
    at(266);
    Rst_n = 1'b1;

    at(305);
    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge Clk);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      tests++; fails++;
      $display("FAIL %s never checked (edge %0d)", e.name, e.c);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
